// File: rtl/cmac_pwr_pkg.sv
// cmac_pwr_pkg: shared types and helpers for the CMAC Q-channel power controller.
//   STATE_W  : width of the FSM state encoding (exported on state_o)
//   state_e  : FSM state enum
//   tmr_w()  : width able to hold the largest timer value without wrapping
package cmac_pwr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 3'd0,
        ST_REQ     = 3'd1,
        ST_DENIED  = 3'd2,
        ST_STOPPED = 3'd3,
        ST_PWRUP   = 3'd4,
        ST_RESTORE = 3'd5,
        ST_EXIT    = 3'd6
    } state_e;

    function automatic int tmr_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cmac_pwr_timer.sv
// cmac_pwr_timer: saturating counter with clear/load/enable and a done flag.
//   clk_i, rst_i : clock, async active-high reset (count resets to 0)
//   clr_i        : synchronous clear (highest priority)
//   ld_i/ld_val_i: synchronous load
//   en_i         : count one step (up, or down when DOWN=1)
//   lim_i        : up mode only, done_o = count >= lim_i
//   done_o       : up mode: limit reached; down mode: count is zero
module cmac_pwr_timer #(
    parameter int W    = 8,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] lim_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            // Saturate at either end so the count never wraps.
            if (DOWN) begin
                if (cnt_q != '0) cnt_d = cnt_q - W'(1);
            end else begin
                if (cnt_q != '1) cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = DOWN ? (cnt_q == '0) : (cnt_q >= lim_i);

endmodule

// File: rtl/cmac_pwr_ctrl.sv
// cmac_pwr_ctrl: Q-channel power controller for the CMAC partition.
// Drops qreqn after a run of idle cycles, enables power-down once CMAC
// accepts, and on wake sequences power-up settle, a one-cycle retention
// restore pulse and Q-channel exit.
//   nvdla_core_clk/rst : clock, async active-high reset
//   idle_i, wake_req_i : datapath idle hint, level wake demand
//   qacceptn_i/qdeny_i : Q-channel responses from CMAC
//   qreqn_o            : Q-channel request (low = quiesce)
//   pr_restore_o       : retention restore pulse
//   pwr_down_o         : power-switch off / retention hold
//   state_o            : FSM state (debug)
//   deny_cnt_o         : saturating denial count
// Build option CMAC_PWR_CTRL_DENY_BACKOFF_EN: after a denial, hold the idle
// timer at 0 for BACKOFF_CYCLES RUN cycles before counting resumes.
module cmac_pwr_ctrl
    import cmac_pwr_pkg::*;
#(
    parameter int IDLE_CYCLES    = 16,
    parameter int PWRUP_CYCLES   = 4,
    parameter int BACKOFF_CYCLES = 32,
    parameter int CNT_W          = 8
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               idle_i,
    input  logic               wake_req_i,
    input  logic               qacceptn_i,
    input  logic               qdeny_i,
    output logic               qreqn_o,
    output logic               pr_restore_o,
    output logic               pwr_down_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   deny_cnt_o
);

    localparam int TW = tmr_w(IDLE_CYCLES, PWRUP_CYCLES, BACKOFF_CYCLES);

    state_e           state_q;
    logic             qreqn_q, pr_restore_q, pwr_down_q;
    logic [CNT_W-1:0] deny_cnt_q;

    logic idle_cond, idle_en, idle_done, boff_busy, pwrup_done, deny_exit, req_go;

    assign idle_cond = idle_i && !wake_req_i;
    assign deny_exit = (state_q == ST_DENIED) && !qdeny_i && qacceptn_i;

`ifdef CMAC_PWR_CTRL_DENY_BACKOFF_EN
    logic boff_done;
    cmac_pwr_timer #(.W(TW), .DOWN(1'b1)) u_boff_tmr (
        .clk_i    (nvdla_core_clk),
        .rst_i    (nvdla_core_rst),
        .clr_i    (1'b0),
        .ld_i     (deny_exit),
        .ld_val_i (TW'(BACKOFF_CYCLES)),
        .en_i     (state_q == ST_RUN),
        .lim_i    ('0),
        .done_o   (boff_done)
    );
    assign boff_busy = !boff_done;
`else
    assign boff_busy = 1'b0;
`endif

    // The idle timer only survives consecutive qualifying RUN cycles; leaving
    // RUN or any non-idle cycle clears it.
    assign idle_en = (state_q == ST_RUN) && idle_cond && !boff_busy;

    cmac_pwr_timer #(.W(TW), .DOWN(1'b0)) u_idle_tmr (
        .clk_i    (nvdla_core_clk),
        .rst_i    (nvdla_core_rst),
        .clr_i    (!idle_en),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (idle_en),
        .lim_i    (TW'(IDLE_CYCLES - 1)),
        .done_o   (idle_done)
    );

    cmac_pwr_timer #(.W(TW), .DOWN(1'b0)) u_pwrup_tmr (
        .clk_i    (nvdla_core_clk),
        .rst_i    (nvdla_core_rst),
        .clr_i    (state_q != ST_PWRUP),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (state_q == ST_PWRUP),
        .lim_i    (TW'(PWRUP_CYCLES - 1)),
        .done_o   (pwrup_done)
    );

    // Timer compares against LIMIT-1 so the request lands on the same edge
    // that completes the last idle cycle. qreqn only falls from an idle
    // Q-channel (accept high, deny low).
    assign req_go = idle_en && idle_done && qacceptn_i && !qdeny_i;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q      <= ST_RUN;
            qreqn_q      <= 1'b1;
            pr_restore_q <= 1'b0;
            pwr_down_q   <= 1'b0;
            deny_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: if (req_go) begin
                    state_q <= ST_REQ;
                    qreqn_q <= 1'b0;
                end
                ST_REQ: begin
                    // Deny wins over a simultaneous accept.
                    if (qdeny_i) begin
                        state_q <= ST_DENIED;
                        qreqn_q <= 1'b1;
                        if (deny_cnt_q != '1) deny_cnt_q <= deny_cnt_q + CNT_W'(1);
                    end else if (!qacceptn_i) begin
                        state_q    <= ST_STOPPED;
                        pwr_down_q <= 1'b1;
                    end
                end
                ST_DENIED: if (deny_exit) state_q <= ST_RUN;
                ST_STOPPED: if (wake_req_i) begin
                    state_q    <= ST_PWRUP;
                    pwr_down_q <= 1'b0;
                end
                ST_PWRUP: if (pwrup_done) begin
                    state_q      <= ST_RESTORE;
                    pr_restore_q <= 1'b1;
                end
                ST_RESTORE: begin
                    state_q      <= ST_EXIT;
                    pr_restore_q <= 1'b0;
                    qreqn_q      <= 1'b1;
                end
                ST_EXIT: if (qacceptn_i) state_q <= ST_RUN;
                default: begin
                    state_q      <= ST_RUN;
                    qreqn_q      <= 1'b1;
                    pr_restore_q <= 1'b0;
                    pwr_down_q   <= 1'b0;
                end
            endcase
        end
    end

    assign qreqn_o      = qreqn_q;
    assign pr_restore_o = pr_restore_q;
    assign pwr_down_o   = pwr_down_q;
    assign state_o      = state_q;
    assign deny_cnt_o   = deny_cnt_q;

endmodule

// File: tb/tb_cmac_pwr_ctrl.sv
// Bench for cmac_pwr_ctrl: expected output snapshots are queued with their
// due cycle while stimulus is driven, then popped and compared as the DUT
// reaches that cycle. A monitor checks the Q-channel handshake rules.
module tb_cmac_pwr_ctrl;
    import cmac_pwr_pkg::*;

    localparam int IDLE  = 16;
    localparam int PWRUP = 4;
    localparam int BOFF  = 32;
    localparam int CW    = 8;
`ifdef CMAC_PWR_CTRL_DENY_BACKOFF_EN
    localparam int REARM = BOFF + IDLE;
`else
    localparam int REARM = IDLE;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          idle = 1'b0, wake = 1'b0, qacc = 1'b1, qdeny = 1'b0;
    logic          qreqn, pr, pd;
    logic [2:0]    st;
    logic [CW-1:0] dc;
    logic [13:0]   obs;

    always #5 clk = ~clk;

    cmac_pwr_ctrl #(
        .IDLE_CYCLES(IDLE), .PWRUP_CYCLES(PWRUP), .BACKOFF_CYCLES(BOFF), .CNT_W(CW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .idle_i         (idle),
        .wake_req_i     (wake),
        .qacceptn_i     (qacc),
        .qdeny_i        (qdeny),
        .qreqn_o        (qreqn),
        .pr_restore_o   (pr),
        .pwr_down_o     (pd),
        .state_o        (st),
        .deny_cnt_o     (dc)
    );

    assign obs = {st, qreqn, pr, pd, dc};

    typedef struct {
        int          at;
        string       tag;
        logic [13:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0, errors = 0, cyc_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Snapshot layout: {state, qreqn, pr_restore, pwr_down, deny_cnt}
    task automatic expect_at(input int n, input string tag, input state_e s,
                             input logic q, input logic r, input logic d, input logic [CW-1:0] c);
        sb_t e;
        e.at  = cyc_n + n;
        e.tag = tag;
        e.exp = {s, q, r, d, c};
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0 && sb[0].at <= cyc_n) begin
            e = sb.pop_front();
            chk(e.tag, {18'b0, obs}, {18'b0, e.exp});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_n++;
            drain();
        end
    endtask

    // Handshake monitor: inputs captured at the edge belong to the cycle
    // that just ended; outputs are read just after the edge.
    logic m_acc, m_dny, m_q, m_pr, m_rst;
    always @(posedge clk) begin
        m_acc = qacc; m_dny = qdeny; m_q = qreqn; m_pr = pr; m_rst = rst;
        #1;
        if (!m_rst && !rst) begin
            if (m_q && !qreqn)
                chk("qreqn_fall_cond", {30'b0, m_acc, m_dny}, 32'b10);
            if (!m_q && qreqn && !(m_dny && !m_acc))
                chk("qreqn_rise_cond", {31'b0, m_acc ^ m_dny}, 32'b0);
            if (!m_pr && pr)
                chk("pr_rise_qreqn", {31'b0, qreqn}, 32'b0);
            if (pd)
                chk("pd_only_stopped", {29'b0, st}, {29'b0, ST_STOPPED});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        expect_at(0, "reset", ST_RUN, 1, 0, 0, 0);
        drain();
        rst = 1'b0;

        // Idle entry: 16 idle cycles, request on the 17th, accept -> power down
        idle = 1'b1;
        expect_at(15, "idle_15", ST_RUN, 1, 0, 0, 0);
        expect_at(16, "req_entry", ST_REQ, 0, 0, 0, 0);
        tick(16);
        qacc = 1'b0;
        expect_at(1, "accept", ST_STOPPED, 0, 0, 1, 0);
        expect_at(2, "stop_hold", ST_STOPPED, 0, 0, 1, 0);
        tick(2);

        // Wake sequence
        wake = 1'b1;
        expect_at(1, "pwrup_first", ST_PWRUP, 0, 0, 0, 0);
        expect_at(4, "pwrup_last", ST_PWRUP, 0, 0, 0, 0);
        expect_at(5, "restore", ST_RESTORE, 0, 1, 0, 0);
        expect_at(6, "exit", ST_EXIT, 1, 0, 0, 0);
        expect_at(7, "exit_hold", ST_EXIT, 1, 0, 0, 0);
        tick(7);
        qacc = 1'b1; wake = 1'b0; idle = 1'b0;
        expect_at(1, "run_back", ST_RUN, 1, 0, 0, 0);
        tick(1);

        // Idle glitch restarts the count
        idle = 1'b1;
        tick(15);
        idle = 1'b0;
        tick(1);
        idle = 1'b1;
        expect_at(15, "glitch_run", ST_RUN, 1, 0, 0, 0);
        expect_at(16, "glitch_req", ST_REQ, 0, 0, 0, 0);
        tick(16);

        // Deny, then re-arm delay
        qdeny = 1'b1;
        expect_at(1, "deny", ST_DENIED, 1, 0, 0, 1);
        expect_at(2, "deny_hold", ST_DENIED, 1, 0, 0, 1);
        tick(2);
        qdeny = 1'b0;
        expect_at(1, "deny_run", ST_RUN, 1, 0, 0, 1);
        expect_at(REARM, "rearm_quiet", ST_RUN, 1, 0, 0, 1);
        expect_at(REARM + 1, "rearm_req", ST_REQ, 0, 0, 0, 1);
        tick(REARM + 1);

        // Deny wins over a simultaneous accept
        qdeny = 1'b1; qacc = 1'b0;
        expect_at(1, "deny_prio", ST_DENIED, 1, 0, 0, 2);
        tick(1);
        qacc = 1'b1;
        expect_at(1, "deny_prio_hold", ST_DENIED, 1, 0, 0, 2);
        tick(1);
        qdeny = 1'b0;
        expect_at(REARM + 1, "rearm2_req", ST_REQ, 0, 0, 0, 2);
        tick(REARM + 1);

        // Early wake during REQ: qreqn held low until accept, one-cycle STOPPED
        wake = 1'b1;
        expect_at(2, "early_hold", ST_REQ, 0, 0, 0, 2);
        tick(2);
        qacc = 1'b0;
        expect_at(1, "early_stop", ST_STOPPED, 0, 0, 1, 2);
        expect_at(2, "early_pwrup", ST_PWRUP, 0, 0, 0, 2);
        expect_at(6, "early_restore", ST_RESTORE, 0, 1, 0, 2);
        expect_at(7, "early_exit", ST_EXIT, 1, 0, 0, 2);
        tick(7);
        qacc = 1'b1; wake = 1'b0;
        expect_at(1, "early_run", ST_RUN, 1, 0, 0, 2);
        tick(1);

        // Async reset in PWRUP
        expect_at(16, "req3", ST_REQ, 0, 0, 0, 2);
        tick(16);
        qacc = 1'b0; wake = 1'b1;
        expect_at(1, "stop3", ST_STOPPED, 0, 0, 1, 2);
        expect_at(3, "pwrup3", ST_PWRUP, 0, 0, 0, 2);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        expect_at(0, "rst_async", ST_RUN, 1, 0, 0, 0);
        drain();
        tick(1);
        rst = 1'b0; qacc = 1'b1; wake = 1'b0; idle = 1'b0;
        expect_at(1, "post_rst", ST_RUN, 1, 0, 0, 0);
        tick(1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
